// File: rtl/package_gen_stream.sv
// Multi-lane packet framer: wraps ADC samples or generated test data into
// header / payload / trailer beats on a single valid/ready output stream.
module package_gen_stream #(
  parameter int NUM_CH = 24,
  parameter int WORD_W = 36,
  parameter int SEQ_W  = 12,
  parameter int LEN_W  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_en,
  input  logic [1:0]                   cfg_mode,
  input  logic [LEN_W-1:0]             cfg_pld_len,
  input  logic [WORD_W-3:0]            cfg_pattern,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_CH*(WORD_W-2)-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_CH*WORD_W-1:0]     out_data,
  output logic                         out_sop,
  output logic                         out_eop,
  output logic [31:0]                  pkt_cnt,
  output logic                         sts_busy
);

  // state | meaning
  // IDLE  | waiting for cfg_en
  // HDR   | header beat pending, config latched
  // PLD   | loading payload beats, down-counting remaining length
  // TRL   | trailer beat pending, carries per-lane checksums

  localparam int DW = WORD_W - 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_PLD  = 2'd2;
  localparam logic [1:0] S_TRL  = 2'd3;

  localparam logic [1:0] TAG_HDR = 2'b01;
  localparam logic [1:0] TAG_PLD = 2'b00;
  localparam logic [1:0] TAG_TRL = 2'b10;

  localparam logic [1:0] MODE_ADC  = 2'd0;
  localparam logic [1:0] MODE_RAMP = 2'd1;

  generate
    if (DW < SEQ_W + LEN_W + 8) begin : g_bad_cfg
      $error("package_gen_stream: WORD_W-2 must be >= SEQ_W+LEN_W+8");
    end
  endgenerate

  logic [1:0]               state_q, state_d;
  logic [1:0]               mode_q, mode_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [LEN_W-1:0]         left_q, left_d;
  logic [SEQ_W-1:0]         seq_q, seq_d;
  logic [DW-1:0]            ramp_q, ramp_d;
  logic [NUM_CH*DW-1:0]     csum_q, csum_d;
  logic [31:0]              pkt_cnt_q, pkt_cnt_d;
  logic                     out_valid_q, out_valid_d;
  logic [NUM_CH*WORD_W-1:0] out_data_q, out_data_d;
  logic                     out_sop_q, out_sop_d;
  logic                     out_eop_q, out_eop_d;

  logic                     load_ok;
  logic                     adc_sel;
  logic                     pld_fire;
  logic [NUM_CH*WORD_W-1:0] hdr_data;
  logic [NUM_CH*WORD_W-1:0] pld_data;
  logic [NUM_CH*WORD_W-1:0] trl_data;
  logic [NUM_CH*DW-1:0]     pld_sum;
  logic [DW-1:0]            hdr_body;
  logic [DW-1:0]            pld_body;

  // Beat datapath: every candidate beat is built in parallel, the FSM picks one.
  always_comb begin
    load_ok  = !out_valid_q || out_ready;
    adc_sel  = (mode_q == MODE_ADC);
    pld_fire = (state_q == S_PLD) && load_ok && (!adc_sel || in_valid);
    hdr_data = '0;
    pld_data = '0;
    trl_data = '0;
    pld_sum  = '0;
    hdr_body = '0;
    pld_body = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hdr_body                 = '0;
      hdr_body[SEQ_W-1:0]      = seq_q;
      hdr_body[SEQ_W +: LEN_W] = len_q;
      hdr_body[DW-8 +: 8]      = 8'(i);
      if (adc_sel) begin
        pld_body = in_data[i*DW +: DW];
      end else if (mode_q == MODE_RAMP) begin
        pld_body = ramp_q + DW'(i);
      end else begin
        pld_body = cfg_pattern;
      end
      pld_sum[i*DW +: DW]         = csum_q[i*DW +: DW] + pld_body;
      hdr_data[i*WORD_W +: WORD_W] = {TAG_HDR, hdr_body};
      pld_data[i*WORD_W +: WORD_W] = {TAG_PLD, pld_body};
      trl_data[i*WORD_W +: WORD_W] = {TAG_TRL, csum_q[i*DW +: DW]};
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    len_d       = len_q;
    left_d      = left_q;
    seq_d       = seq_q;
    ramp_d      = ramp_q;
    csum_d      = csum_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    pkt_cnt_d   = pkt_cnt_q + {31'd0, out_valid_q && out_ready && out_eop_q};

    case (state_q)
      S_IDLE: begin
        if (cfg_en) begin
          state_d = S_HDR;
          mode_d  = cfg_mode;
          len_d   = cfg_pld_len;
        end
      end
      S_HDR: begin
        if (load_ok) begin
          out_valid_d = 1'b1;
          out_data_d  = hdr_data;
          out_sop_d   = 1'b1;
          out_eop_d   = 1'b0;
          csum_d      = '0;
          left_d      = len_q;
          state_d     = (len_q == '0) ? S_TRL : S_PLD;
        end
      end
      S_PLD: begin
        if (pld_fire) begin
          out_valid_d = 1'b1;
          out_data_d  = pld_data;
          out_sop_d   = 1'b0;
          out_eop_d   = 1'b0;
          csum_d      = pld_sum;
          left_d      = left_q - 1'b1;
          if (mode_q == MODE_RAMP) ramp_d = ramp_q + 1'b1;
          if (left_q == LEN_W'(1)) state_d = S_TRL;
        end
      end
      S_TRL: begin
        if (load_ok) begin
          out_valid_d = 1'b1;
          out_data_d  = trl_data;
          out_sop_d   = 1'b0;
          out_eop_d   = 1'b1;
          seq_d       = seq_q + 1'b1;
          // Back-to-back packets re-latch the config on the way into HDR.
          if (cfg_en) begin
            state_d = S_HDR;
            mode_d  = cfg_mode;
            len_d   = cfg_pld_len;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      len_q       <= '0;
      left_q      <= '0;
      seq_q       <= '0;
      ramp_q      <= '0;
      csum_q      <= '0;
      pkt_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      left_q      <= left_d;
      seq_q       <= seq_d;
      ramp_q      <= ramp_d;
      csum_q      <= csum_d;
      pkt_cnt_q   <= pkt_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
    end
  end

  assign in_ready  = (state_q == S_PLD) && adc_sel && load_ok;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign sts_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_package_gen_stream.sv
// Bench for package_gen_stream: randomized traffic compared beat-by-beat
// against a packet-level reference model, plus directed boundary cases.
module tb_package_gen_stream;
  localparam int NC = 24;
  localparam int WW = 36;
  localparam int DW = WW - 2;
  localparam int SW = 12;
  localparam int LW = 8;
  localparam int VW = NC * WW;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           cfg_en = 1'b0;
  logic [1:0]     cfg_mode = 2'd0;
  logic [LW-1:0]  cfg_pld_len = '0;
  logic [DW-1:0]  cfg_pattern = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [NC*DW-1:0] in_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [VW-1:0]  out_data;
  logic           out_sop;
  logic           out_eop;
  logic [31:0]    pkt_cnt;
  logic           sts_busy;

  package_gen_stream #(.NUM_CH(NC), .WORD_W(WW), .SEQ_W(SW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_mode(cfg_mode),
    .cfg_pld_len(cfg_pld_len), .cfg_pattern(cfg_pattern),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .pkt_cnt(pkt_cnt), .sts_busy(sts_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [VW-1:0] d;
    logic          sop;
    logic          eop;
  } beat_t;

  beat_t            exp_q[$];
  beat_t            got_q[$];
  logic [NC*DW-1:0] adc_src[$];
  logic [NC*DW-1:0] adc_model[$];

  int checks = 0;
  int failures = 0;

  longint unsigned m_seq = 0, m_ramp = 0, m_pkt = 0;

  int rdy_pct = 100, vld_pct = 100, force_low = 0, force_at = -1;
  int hdr_seen = 0, stop_at_hdr = 0, chg_at_hdr = 0, chg_len = 0;
  int drop_dly = 0, drop_pend = 0;

  logic             prev_stall = 1'b0;
  logic [VW-1:0]    prev_data = '0;
  logic             prev_sop = 1'b0, prev_eop = 1'b0;
  logic             prev_in_hs = 1'b0;
  logic [NC*DW-1:0] prev_smp = '0;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] trunc(input longint unsigned v);
    logic [63:0] t;
    t = v;
    return t[DW-1:0];
  endfunction

  function automatic logic [NC*DW-1:0] rand_smp();
    logic [NC*DW-1:0] s;
    logic [63:0] r;
    s = '0;
    for (int i = 0; i < NC; i++) begin
      r = {$urandom(), $urandom()};
      s[i*DW +: DW] = r[DW-1:0];
    end
    return s;
  endfunction

  function automatic logic [VW-1:0] adc_beat(input logic [NC*DW-1:0] s);
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < NC; i++) v[i*WW +: WW] = {2'b00, s[i*DW +: DW]};
    return v;
  endfunction

  // Reference packet: header, len payload beats, trailer of per-lane sums.
  function automatic void build_pkt(input int mode, input int len, input logic [DW-1:0] pat);
    beat_t            b;
    longint unsigned  sum [NC];
    longint unsigned  body;
    longint unsigned  modv;
    logic [NC*DW-1:0] smp;
    logic [DW-1:0]    lb;
    modv = 64'd1 << DW;
    smp = '0;
    b.d = '0; b.sop = 1'b1; b.eop = 1'b0;
    for (int i = 0; i < NC; i++) begin
      body = m_seq + (longint'(len % 256) << SW) + (longint'(i) << (DW - 8));
      b.d[i*WW +: WW] = {2'b01, trunc(body)};
      sum[i] = 0;
    end
    exp_q.push_back(b);
    for (int k = 0; k < len; k++) begin
      b.sop = 1'b0; b.eop = 1'b0;
      if (mode == 0) smp = adc_model.pop_front();
      for (int i = 0; i < NC; i++) begin
        if (mode == 0) begin
          lb = smp[i*DW +: DW];
          body = {30'd0, lb};
        end else if (mode == 1) begin
          body = (m_ramp + longint'(i)) % modv;
        end else begin
          body = {30'd0, pat};
        end
        sum[i] = (sum[i] + body) % modv;
        b.d[i*WW +: WW] = {2'b00, trunc(body)};
      end
      exp_q.push_back(b);
      if (mode == 1) m_ramp = (m_ramp + 1) % modv;
    end
    b.sop = 1'b0; b.eop = 1'b1;
    for (int i = 0; i < NC; i++) b.d[i*WW +: WW] = {2'b10, trunc(sum[i])};
    exp_q.push_back(b);
    m_seq = (m_seq + 1) % 4096;
    m_pkt++;
  endfunction

  // One clock: drive at negedge, sample #1 later for the handshake at the next posedge.
  task automatic step();
    logic nh;
    @(negedge clk);
    out_ready = ($urandom_range(99) < rdy_pct);
    if (force_low > 0) begin
      out_ready = 1'b0;
      force_low--;
    end
    if (adc_src.size() > 0 && $urandom_range(99) < vld_pct) begin
      in_valid = 1'b1;
      in_data  = adc_src[0];
    end else begin
      in_valid = 1'b0;
    end
    #1;
    if (prev_stall) begin
      chk("hold_data", out_data, prev_data);
      chk("hold_flags", VW'({out_valid, out_sop, out_eop}), VW'({1'b1, prev_sop, prev_eop}));
    end
    if (prev_in_hs) begin
      chk("adc_latency", out_data, adc_beat(prev_smp));
      chk("adc_lat_flags", VW'({out_valid, out_sop, out_eop}), VW'(3'b100));
    end
    if (drop_pend > 0) begin
      drop_pend--;
      if (drop_pend == 0) cfg_en = 1'b0;
    end
    nh = out_valid && out_sop && !prev_stall;
    if (nh) begin
      hdr_seen++;
      if (hdr_seen == stop_at_hdr) begin
        if (drop_dly == 0) cfg_en = 1'b0;
        else drop_pend = drop_dly;
      end
      if (hdr_seen == chg_at_hdr) cfg_pld_len = LW'(chg_len);
    end
    prev_in_hs = in_valid && in_ready;
    if (prev_in_hs) begin
      prev_smp = in_data;
      void'(adc_src.pop_front());
    end
    if (out_valid && out_ready) begin
      got_q.push_back({out_data, out_sop, out_eop});
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL extra_beat observed=1 expected=0");
      end
      if (exp_q.size() > 0) begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat_data", out_data, e.d);
        chk("beat_flags", VW'({out_sop, out_eop}), VW'({e.sop, e.eop}));
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_sop   = out_sop;
    prev_eop   = out_eop;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    cfg_en = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_out_data", out_data, '0);
    chk("rst_flags", VW'({out_valid, out_sop, out_eop, sts_busy, in_ready}), '0);
    chk("rst_pkt_cnt", VW'(pkt_cnt), '0);
    exp_q.delete(); got_q.delete(); adc_src.delete(); adc_model.delete();
    m_seq = 0; m_ramp = 0; m_pkt = 0;
    prev_stall = 1'b0; prev_in_hs = 1'b0;
    force_low = 0; hdr_seen = 0; drop_pend = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_pkts(input int mode, input int len, input int npk,
                          input logic [DW-1:0] pat, input int budget);
    int n, need, l;
    logic [NC*DW-1:0] s;
    need = 0;
    for (int p = 0; p < npk; p++) need += (chg_at_hdr != 0 && p >= chg_at_hdr) ? chg_len : len;
    if (mode == 0) begin
      while (adc_model.size() < need) begin
        s = rand_smp();
        adc_src.push_back(s);
        adc_model.push_back(s);
      end
    end
    for (int p = 0; p < npk; p++) begin
      l = (chg_at_hdr != 0 && p >= chg_at_hdr) ? chg_len : len;
      build_pkt(mode, l, pat);
    end
    got_q.delete();
    hdr_seen = 0;
    stop_at_hdr = npk;
    cfg_mode = 2'(mode);
    cfg_pld_len = LW'(len);
    cfg_pattern = pat;
    cfg_en = 1'b1;
    n = 0;
    while (!(exp_q.size() == 0 && !out_valid && !sts_busy) && n < budget) begin
      step();
      n++;
      if (n == force_at) force_low = 3;
    end
    checks++;
    assert (n < budget) else begin
      failures++;
      $error("FAIL timeout observed=%0d expected_below=%0d", n, budget);
    end
    chk("pkt_cnt", VW'(pkt_cnt), VW'(m_pkt[31:0]));
    chk("idle_busy", VW'({sts_busy, out_valid}), '0);
    chg_at_hdr = 0;
    force_at = -1;
  endtask

  initial begin
    logic [NC*DW-1:0] s;
    logic [63:0] r;
    apply_reset();

    // Ramp, len 4, no backpressure: directed values.
    rdy_pct = 100;
    run_pkts(1, 4, 1, '0, 200);
    chk("n_beats", VW'(got_q.size()), VW'(6));
    chk("hdr_lane3", VW'(got_q[0].d[3*WW +: WW]), VW'(36'h4_0C00_4000));
    for (int k = 0; k < 4; k++) chk("ramp_lane0", VW'(got_q[1+k].d[0 +: WW]), VW'(k));
    chk("trl_lane0", VW'(got_q[5].d[0 +: WW]), VW'(36'h8_0000_0006));
    chk("trl_lane5_body", VW'(got_q[5].d[5*WW +: DW]), VW'(26));

    // Ramp with a 3-cycle stall mid-payload, then random backpressure.
    force_at = 5;
    run_pkts(1, 6, 2, '0, 400);
    rdy_pct = 50;
    run_pkts(1, int'($urandom_range(8, 1)), 3, '0, 1000);

    // Pattern mode and reserved mode.
    rdy_pct = 70;
    r = {$urandom(), $urandom()};
    run_pkts(2, 3, 2, r[DW-1:0], 500);
    r = {$urandom(), $urandom()};
    run_pkts(3, 5, 1, r[DW-1:0], 500);

    // ADC, len 2, lane0 checksum wraps to zero.
    rdy_pct = 100; vld_pct = 100;
    s = rand_smp(); s[0 +: DW] = 34'h1;
    adc_src.push_back(s); adc_model.push_back(s);
    s = rand_smp(); s[0 +: DW] = 34'h3_FFFF_FFFF;
    adc_src.push_back(s); adc_model.push_back(s);
    run_pkts(0, 2, 1, '0, 200);
    chk("adc_trl_lane0", VW'(got_q[got_q.size()-1].d[0 +: WW]), VW'(36'h8_0000_0000));

    // ADC with random bubbles and backpressure.
    rdy_pct = 60; vld_pct = 60;
    run_pkts(0, 5, 2, '0, 1000);
    chk("adc_consumed", VW'(adc_src.size()), '0);

    // Length changed after the first header only affects the second packet.
    rdy_pct = 80;
    chg_at_hdr = 1; chg_len = 7;
    run_pkts(1, 3, 2, '0, 500);

    // cfg_en dropped mid-payload: the packet still completes.
    rdy_pct = 100; drop_dly = 3;
    run_pkts(1, 8, 1, '0, 300);
    drop_dly = 0;

    // Reset in the middle of payload.
    build_pkt(1, 8, '0);
    cfg_mode = 2'd1; cfg_pld_len = 8'd8; cfg_en = 1'b1;
    repeat (5) step();
    apply_reset();

    // Empty packets back to back after reset.
    run_pkts(1, 0, 3, '0, 200);
    for (int p = 0; p < 3; p++) begin
      chk("len0_seq", VW'(got_q[2*p].d[0 +: SW]), VW'(p));
      chk("len0_trl", VW'(got_q[2*p+1].d[0 +: WW]), VW'(36'h8_0000_0000));
    end
    chk("len0_pkt_cnt", VW'(pkt_cnt), VW'(3));

    // Sequence number wrap.
    apply_reset();
    r = {$urandom(), $urandom()};
    run_pkts(2, 0, 4097, r[DW-1:0], 20000);
    chk("wrap_seq", VW'(got_q[8192].d[0 +: SW]), '0);
    chk("wrap_pkt_cnt", VW'(pkt_cnt), VW'(4097));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
